// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side 4-slot TDM de-interleaver with slot-0 sync tracking
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sync,
  input  logic [WIDTH-1:0]   in_data,
  output logic [4*WIDTH-1:0] ch_data,
  output logic [3:0]         ch_valid,
  output logic [4*WIDTH-1:0] frame_data,
  output logic               frame_valid,
  output logic               locked,
  output logic [1:0]         slot,
  output logic               sync_err
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t             state_q, state_d;
  logic [1:0]         slot_q, slot_d, idx;
  logic [4*WIDTH-1:0] ch_data_q, ch_data_d, frame_data_q, frame_data_d;
  logic [3:0]         ch_valid_q, ch_valid_d;
  logic               frame_valid_q, frame_valid_d, sync_err_q, sync_err_d;
  logic               acc, miss;
  // accept a sample on sync, or on any non-zero slot while locked; a sync always restarts at slot 0
  always_comb begin
    acc           = in_valid & (in_sync | (state_q == LOCKED & slot_q != 2'd0));
    miss          = in_valid & state_q == LOCKED & !in_sync & slot_q == 2'd0;
    idx           = in_sync ? 2'd0 : slot_q;
    sync_err_d    = in_valid & state_q == LOCKED & (in_sync ? slot_q != 2'd0 : slot_q == 2'd0);
    state_d       = acc ? LOCKED : miss ? HUNT : state_q;
    slot_d        = acc ? idx + 2'd1 : miss ? 2'd0 : slot_q;
    ch_valid_d    = acc ? 4'(1) << idx : 4'd0;
    frame_valid_d = acc & idx == 2'd3;
    frame_data_d  = frame_valid_d ? {in_data, ch_data_q[3*WIDTH-1:0]} : frame_data_q;
    ch_data_d     = ch_data_q;
    if (acc) ch_data_d[idx*WIDTH +: WIDTH] = in_data;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      ch_data_q     <= '0;
      ch_valid_q    <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      ch_data_q     <= ch_data_d;
      ch_valid_q    <= ch_valid_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end
  assign ch_data     = ch_data_q;
  assign ch_valid    = ch_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign locked      = state_q == LOCKED;
  assign slot        = slot_q;
  assign sync_err    = sync_err_q;
endmodule
